alpha_gain_exchanger: RTL
=========================

Name: alpha_gain_exchanger

Overview:
- Sits directly downstream of the alpha (gain-decision) block.
- Consumes its `alpha` flag together with the high-gain (HG) and low-gain (LG) 9-bit signed sample streams.
- Drives the front-end gain-control line immediately on a decision change. The output data mux switches paths only after a programmable settling delay, which covers analog pipeline latency.
- Produces one gain-normalised sample per sampling strobe.

Parameters:
- GAIN_SHIFT, 4: LG path scaling, left shift by this amount (LG gain = HG gain / 2^GAIN_SHIFT).
- SETTLE_SAMPLES, 3: strobes between a gain_ctrl change and the data path following it. Legal range 1..255.

Ports:
- clk  in  1: clock.
- reset  in  1: asynchronous, active-low reset.
- enable_sampling  in  1: sample strobe, one-cycle pulse per sample. All state advances only on strobe cycles.
- alpha  in  1: gain decision from the alpha block. 1 = low gain (large signal); 0 = high gain.
- hg_sample  in  9: signed two's-complement HG channel sample.
- lg_sample  in  9: signed two's-complement LG channel sample.
- out_sample  out  9+GAIN_SHIFT: signed normalised sample.
- out_valid  out  1: one-cycle pulse, cycle after each strobe.
- gain_ctrl  out  1: front-end gain select. 1 = LG.
- path_sel  out  1: data path currently muxed to output. 1 = LG.
- switching  out  1: high while a path change is pending.

Behaviour:

Reset (async, active low) values:
- State LG_STABLE.
- gain_ctrl = 1, path_sel = 1.
- Settle counter = 0.
- out_sample = 0, out_valid = 0, switching = 0.
- Reset asserted mid-switch aborts the switch immediately.

Strobe gating:
- When enable_sampling = 0, all registers hold, except out_valid, which is 0.
- alpha, hg_sample and lg_sample are sampled only on strobe cycles.

State machine (transitions evaluated on strobe cycles only). `cnt` is 8 bits.
- LG_STABLE:
  - alpha = 0 → gain_ctrl <= 0, cnt <= SETTLE_SAMPLES, go to TO_HG.
  - Otherwise stay.
- HG_STABLE:
  - alpha = 1 → gain_ctrl <= 1, cnt <= SETTLE_SAMPLES, go to TO_LG.
  - Otherwise stay.
- TO_LG:
  - alpha = 0 (reversion) → gain_ctrl <= 0, cnt <= SETTLE_SAMPLES, go to TO_HG.
  - Else if cnt == 1 → path_sel <= 1, cnt <= 0, go to LG_STABLE.
  - Else cnt <= cnt − 1.
- TO_HG: mirror of TO_LG (reversion on alpha = 1; on expiry path_sel <= 0, go to HG_STABLE).
- switching = 1 exactly in TO_LG / TO_HG.

Output datapath:
- On each strobe, out_sample is computed from the path_sel value being written that same strobe (next-value mux).
- Consequence: if the decision changes at strobe k, strobes k .. k+SETTLE_SAMPLES−1 use the old path and strobe k+SETTLE_SAMPLES is the first to use the new path. This holds for SETTLE_SAMPLES = 1 as well.
- HG path: out_sample = sign-extend(hg_sample) to 9+GAIN_SHIFT bits.
- LG path: out_sample = sign-extend(lg_sample) << GAIN_SHIFT (low bits zero).
- No saturation is needed; the width is exact.
- out_valid = 1 in the cycle after each strobe; out_sample is updated in that same cycle and holds between strobes.

Latency:
- gain_ctrl: one clock after the deciding strobe.
- out_sample / out_valid: one clock after the strobe.

Boundary conditions:
- Reversion exactly on the expiry strobe (cnt == 1 and alpha reversed): reversion wins. path_sel is unchanged and the counter reloads.
- Back-to-back strobes (enable_sampling held high): every cycle is a sample; the behaviour is identical.
- alpha toggling between strobes is ignored.

Test Plan:
1. Reset with alpha = 1, then 5 strobes, hg = 9'h005, lg = 9'h1FF (−1) → gain_ctrl = 1, path_sel = 1, switching = 0; each out_sample = 13'h1FF0 (−16), each with an out_valid pulse.
2. Settle into HG_STABLE with alpha = 0, then alpha = 1 from strobe k (SETTLE = 3), hg = 100, lg = 10:
   - gain_ctrl = 1 one clock after k.
   - out = 100 at strobes k, k+1, k+2.
   - out = 160 from strobe k+3.
   - switching high from k through k+2, low after k+3.
3. Reversion: in TO_LG at cnt = 2, drive alpha = 0 → gain_ctrl back to 0, state TO_HG, path_sel stays 0, and the output never shows an LG sample.
4. Strobe gating: alpha changes while enable_sampling = 0 for 20 cycles → no state, gain_ctrl or out changes, and out_valid stays 0.
5. Reset asserted (async, mid-clock) during TO_HG with cnt = 2 → all outputs go to their reset values immediately. After release, the block resumes in LG_STABLE.
6. Extreme values on HG path: hg = 9'h100 (−256) → out = 13'h1F00. hg = 9'h0FF → out = 13'h00FF.

Source files
------------

// File: rtl/alpha_gain_exchanger.sv
// rtl/alpha_gain_exchanger.sv - gain-control exchanger with settled HG/LG data path switching
module alpha_gain_exchanger #(
    parameter int GAIN_SHIFT     = 4,
    parameter int SETTLE_SAMPLES = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable_sampling,
    input  logic                    alpha,
    input  logic [8:0]              hg_sample,
    input  logic [8:0]              lg_sample,
    output logic [9+GAIN_SHIFT-1:0] out_sample,
    output logic                    out_valid,
    output logic                    gain_ctrl,
    output logic                    path_sel,
    output logic                    switching
);

    localparam int OW = 9 + GAIN_SHIFT;
    localparam logic [7:0] SETTLE = 8'(SETTLE_SAMPLES);

    typedef enum logic [1:0] {
        LG_STABLE,
        HG_STABLE,
        TO_LG,
        TO_HG
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       expire;
    logic       path_next;
    logic [OW-1:0] hg_ext;
    logic [OW-1:0] lg_ext;

    assign expire = (cnt == 8'd1);

    // Reversion on the expiry strobe must win, so expiry only counts when alpha still agrees.
    assign path_next = (state == TO_LG && alpha && expire)  ? 1'b1 :
                       (state == TO_HG && !alpha && expire) ? 1'b0 :
                       path_sel;

    assign hg_ext = {{GAIN_SHIFT{hg_sample[8]}}, hg_sample};
    assign lg_ext = {lg_sample, {GAIN_SHIFT{1'b0}}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= LG_STABLE;
            cnt        <= 8'd0;
            gain_ctrl  <= 1'b1;
            path_sel   <= 1'b1;
            switching  <= 1'b0;
            out_sample <= '0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= enable_sampling;
            if (enable_sampling) begin
                path_sel   <= path_next;
                out_sample <= path_next ? lg_ext : hg_ext;
                case (state)
                    LG_STABLE: begin
                        if (!alpha) begin
                            gain_ctrl <= 1'b0;
                            cnt       <= SETTLE;
                            state     <= TO_HG;
                            switching <= 1'b1;
                        end
                    end
                    HG_STABLE: begin
                        if (alpha) begin
                            gain_ctrl <= 1'b1;
                            cnt       <= SETTLE;
                            state     <= TO_LG;
                            switching <= 1'b1;
                        end
                    end
                    TO_LG: begin
                        if (!alpha) begin
                            gain_ctrl <= 1'b0;
                            cnt       <= SETTLE;
                            state     <= TO_HG;
                        end else if (expire) begin
                            cnt       <= 8'd0;
                            state     <= LG_STABLE;
                            switching <= 1'b0;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    TO_HG: begin
                        if (alpha) begin
                            gain_ctrl <= 1'b1;
                            cnt       <= SETTLE;
                            state     <= TO_LG;
                        end else if (expire) begin
                            cnt       <= 8'd0;
                            state     <= HG_STABLE;
                            switching <= 1'b0;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    default: begin
                        state     <= LG_STABLE;
                        switching <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
